// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO: one inferred RAM, registered read port, sticky error flags.
// Define PARAM_FIFO_FWFT_EN for first-word-fall-through mode (head word shown before rd).
module param_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 512,
    parameter int AFULL_LEVEL = DEPTH - 16,
    localparam int ADDR_W     = $clog2(DEPTH),
    localparam int CNT_W      = ADDR_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_ready,
    output logic                  full,
    output logic                  almost_full,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("param_fifo: DATA_WIDTH must be >= 1");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("param_fifo: DEPTH must be a power of 2 and >= 4");
    end
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
        $error("param_fifo: AFULL_LEVEL must be in 1..DEPTH");
    end

    // Handshake: a write is taken when wr && !full, a read when rd && data_ready;
    // either request outside those conditions is dropped and flagged as an error.
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      ram_count;
    logic                  ram_empty;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  ram_rd;

    assign ram_count = wr_ptr - rd_ptr;
    assign ram_empty = (wr_ptr == rd_ptr);
    assign wr_ok     = wr && !full && !reset;
    assign rd_ok     = rd && data_ready;

`ifdef PARAM_FIFO_FWFT_EN
    // The output register is an extra stage that is refilled whenever it is empty or being popped.
    logic out_valid;

    assign ram_rd     = !ram_empty && (!out_valid || rd_ok);
    assign data_ready = out_valid;
    assign count      = ram_count + CNT_W'(out_valid);
    assign full       = (count == CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
        end else if (ram_rd) begin
            out_valid <= 1'b1;
        end else if (rd_ok) begin
            out_valid <= 1'b0;
        end
    end
`else
    logic ram_full;

    assign ram_full   = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign ram_rd     = rd_ok;
    assign data_ready = !ram_empty;
    assign count      = ram_count;
    assign full       = ram_full;
`endif

    assign almost_full = (count >= CNT_W'(AFULL_LEVEL));

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[ADDR_W-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ram_rd) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= mem[rd_ptr[ADDR_W-1:0]];
            end
            // A fresh error in the same cycle as clr_err keeps the flag set.
            overflow  <= (wr && full) || (overflow && !clr_err);
            underflow <= (rd && !data_ready) || (underflow && !clr_err);
        end
    end

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo (DEPTH=16, AFULL_LEVEL=12): vector table plus multi-cycle sequences.
// The vector table covers standard mode; sequences adapt to PARAM_FIFO_FWFT_EN.
module tb_param_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [DW-1:0]    data_in = '0;
    logic             wr = 1'b0;
    logic             rd = 1'b0;
    logic             clr_err = 1'b0;
    logic [DW-1:0]    data_out;
    logic             data_ready;
    logic             full;
    logic             almost_full;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    param_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .wr(wr), .rd(rd),
        .data_out(data_out), .data_ready(data_ready), .full(full),
        .almost_full(almost_full), .count(count), .overflow(overflow),
        .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic          rd;
        logic          clr;
        logic [DW-1:0] din;
        int            cnt;
        logic          dr;
        logic          ovf;
        logic          unf;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
        tick();
    endtask

    task automatic clear_errors();
        wr = 1'b0; rd = 1'b0; clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        wr = 1'b1; rd = 1'b0; data_in = d;
        tick();
        wr = 1'b0;
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
    endtask

    // Pops the head word (optionally writing at the same time) and checks data and count.
    task automatic pop(input string name, input bit also_wr, input logic [DW-1:0] d);
        logic [DW-1:0] e;
        bit wr_taken;
        e = exp_q[0];
        wr_taken = also_wr && (exp_q.size() < DEPTH);
`ifdef PARAM_FIFO_FWFT_EN
        chk({name, "_ready"}, 32'(data_ready), 32'd1);
        chk(name, 32'(data_out), 32'(e));
`endif
        rd = 1'b1; wr = also_wr; data_in = d;
        tick();
        rd = 1'b0; wr = 1'b0;
        void'(exp_q.pop_front());
        if (wr_taken) exp_q.push_back(d);
`ifndef PARAM_FIFO_FWFT_EN
        chk(name, 32'(data_out), 32'(e));
`endif
        chk({name, "_cnt"}, 32'(count), 32'(exp_q.size()));
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) pop(name, 1'b0, '0);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        //              wr    rd    clr   din    cnt dr    ovf   unf   dout
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h22, 2, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h33, 3, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h44, 4, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3, 1'b1, 1'b0, 1'b0, 8'h11};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2, 1'b1, 1'b0, 1'b0, 8'h22};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b1, 1'b0, 1'b0, 8'h33};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h44};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h44};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 8'h55, 1, 1'b1, 1'b0, 1'b1, 8'h44};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h55};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b1, 8'h55};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h55};

        reset = 1'b1;
        idle();
        idle();
        reset = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(data_ready), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);

`ifndef PARAM_FIFO_FWFT_EN
        for (int i = 0; i < 15; i++) begin
            wr = vecs[i].wr; rd = vecs[i].rd; clr_err = vecs[i].clr; data_in = vecs[i].din;
            tick();
            chk($sformatf("vec%0d_cnt", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_ready", i), 32'(data_ready), 32'(vecs[i].dr));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d_unf", i), 32'(underflow), 32'(vecs[i].unf));
            chk($sformatf("vec%0d_dout", i), 32'(data_out), 32'(vecs[i].dout));
        end
        idle();
`else
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("empty_rd_unf", 32'(underflow), 32'd1);
        chk("empty_rd_dout", 32'(data_out), 32'd0);
        clear_errors();
        chk("clr_unf", 32'(underflow), 32'd0);
`endif

        // Fill to full, then overflow, then overflow with a simultaneous accepted read.
        for (int i = 0; i < DEPTH; i++) begin
            push(8'hA0 + 8'(i));
            chk($sformatf("fill%0d_cnt", i), 32'(count), 32'(i + 1));
            if (i == AFULL - 2) chk("fill_afull_lo", 32'(almost_full), 32'd0);
            if (i == AFULL - 1) chk("fill_afull_hi", 32'(almost_full), 32'd1);
        end
        chk("fill_full", 32'(full), 32'd1);
        push(8'hEE);
        chk("ovf_cnt", 32'(count), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_full", 32'(full), 32'd1);
        clear_errors();
        chk("ovf_clr", 32'(overflow), 32'd0);
        pop("full_wr_rd", 1'b1, 8'hEF);
        chk("full_wr_rd_ovf", 32'(overflow), 32'd1);
        drain("drain_full");
        chk("drain_ready", 32'(data_ready), 32'd0);
        chk("drain_full_flag", 32'(full), 32'd0);
        clear_errors();

        // Almost-full threshold on the way down.
        for (int i = 0; i < AFULL; i++) push(8'h60 + 8'(i));
        chk("afull_at_level", 32'(almost_full), 32'd1);
        pop("afull_pop", 1'b0, '0);
        chk("afull_below", 32'(almost_full), 32'd0);
        drain("drain_afull");

        // Half full, simultaneous read/write streaming across pointer wrap.
        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
        idle();
        for (int k = 0; k < 40; k++) pop($sformatf("stream%0d", k), 1'b1, 8'h40 + 8'(k));
        chk("stream_ovf", 32'(overflow), 32'd0);
        chk("stream_unf", 32'(underflow), 32'd0);
        drain("drain_stream");

        // Reset mid-operation with a write requested on the reset edge.
        for (int i = 0; i < 5; i++) push(8'h70 + 8'(i));
        reset = 1'b1; wr = 1'b1; data_in = 8'h99;
        tick();
        reset = 1'b0; wr = 1'b0;
        exp_q.delete();
        chk("midrst_cnt", 32'(count), 32'd0);
        chk("midrst_ready", 32'(data_ready), 32'd0);
        chk("midrst_full", 32'(full), 32'd0);
        chk("midrst_afull", 32'(almost_full), 32'd0);
        chk("midrst_dout", 32'(data_out), 32'd0);

        push(8'hA5);
`ifdef PARAM_FIFO_FWFT_EN
        chk("first_wr_ready_e1", 32'(data_ready), 32'd0);
        idle();
        chk("first_wr_ready_e2", 32'(data_ready), 32'd1);
        chk("first_wr_dout_e2", 32'(data_out), 32'hA5);
`else
        chk("first_wr_ready_e1", 32'(data_ready), 32'd1);
        chk("first_wr_dout_held", 32'(data_out), 32'd0);
`endif
        chk("first_wr_cnt", 32'(count), 32'd1);
        pop("post_rst_pop", 1'b0, '0);
        chk("post_rst_ready", 32'(data_ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
